// File: rtl/display_sequencer.sv
// display_sequencer: buffers 5-bit symbol codes and plays them out on C1..C5 with a fixed dwell per symbol
module display_sequencer #(
  parameter int DEPTH = 8,
  parameter int DWELL = 4,
  parameter logic [4:0] BLANK = 5'b11111
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_valid,
  input  logic [4:0] wr_code,
  output logic wr_ready,
  input  logic clear,
  input  logic start,
  input  logic loop,
  input  logic stop,
  output logic busy,
  output logic done,
  output logic [$clog2(DEPTH):0] count,
  output logic C1,
  output logic C2,
  output logic C3,
  output logic C4,
  output logic C5
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_n;
  logic [4:0] mem [DEPTH];
  logic [AW:0] count_n;
  logic [AW-1:0] idx, idx_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [4:0] code, code_n;
  logic loop_q, loop_n, busy_n, done_n, we, last_dwell, last_idx;
  assign wr_ready = state == IDLE && count < (AW+1)'(DEPTH);
  assign {C1, C2, C3, C4, C5} = code;
  assign last_dwell = dwell == DW'(DWELL - 1);
  assign last_idx = {1'b0, idx} + (AW+1)'(1) >= count;
  always_comb begin
    state_n = state;
    count_n = count;
    idx_n = idx;
    dwell_n = dwell;
    loop_n = loop_q;
    code_n = code;
    busy_n = busy;
    done_n = 1'b0;
    we = 1'b0;
    if (state == IDLE) begin
      we = !clear && wr_valid && wr_ready;
      count_n = clear ? '0 : count + (AW+1)'(we);
      if (start && !clear && count != '0) begin
        state_n = PLAY;
        loop_n = loop;
        idx_n = '0;
        dwell_n = '0;
        code_n = mem[0];
        busy_n = 1'b1;
      end
    end else if (stop || (last_dwell && last_idx && !loop_q)) begin
      state_n = IDLE;
      code_n = BLANK;
      busy_n = 1'b0;
      done_n = 1'b1;
    end else if (last_dwell) begin
      idx_n = last_idx ? '0 : idx + AW'(1);
      dwell_n = '0;
      code_n = mem[idx_n];
    end else begin
      dwell_n = dwell + DW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      idx <= '0;
      dwell <= '0;
      loop_q <= 1'b0;
      code <= BLANK;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      idx <= idx_n;
      dwell <= dwell_n;
      loop_q <= loop_n;
      code <= code_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
  always_ff @(posedge clk)
    if (we) mem[count[AW-1:0]] <= wr_code;
endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: directed stimulus with a frame scoreboard checked by a negedge monitor
module tb_display_sequencer;
  logic clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, clear = 1'b0, start = 1'b0, loop = 1'b0, stop = 1'b0;
  logic [4:0] wr_code = '0;
  logic wr_ready, busy, done, C1, C2, C3, C4, C5;
  logic [3:0] count;
  logic [4:0] code;
  logic [6:0] q[$];
  logic mon_en = 1'b0;
  int n_cmp = 0, n_bad = 0;
  display_sequencer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_code(wr_code), .wr_ready(wr_ready),
    .clear(clear), .start(start), .loop(loop), .stop(stop), .busy(busy), .done(done),
    .count(count), .C1(C1), .C2(C2), .C3(C3), .C4(C4), .C5(C5)
  );
  assign code = {C1, C2, C3, C4, C5};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_sym(input logic [4:0] c, input int n);
    for (int i = 0; i < n; i++) q.push_back({1'b1, 1'b0, c});
  endtask
  task automatic push_done();
    q.push_back({1'b0, 1'b1, 5'b11111});
  endtask
  task automatic write(input logic [4:0] c);
    wr_valid = 1'b1;
    wr_code = c;
    tick();
    wr_valid = 1'b0;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  task automatic go(input logic lp);
    start = 1'b1;
    loop = lp;
    tick();
    start = 1'b0;
    loop = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk("drain_left", q.size(), 0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_code", code, 5'b11111);
  endtask
  always @(negedge clk) begin
    if (mon_en && (busy || done)) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {busy, done, code}, 0);
      end else begin
        logic [6:0] e;
        e = q.pop_front();
        chk("frame", {busy, done, code}, e);
      end
    end
  end
  initial begin
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_code", code, 5'b11111);
    chk("rst_ready", wr_ready, 1);
    rst = 1'b0;
    mon_en = 1'b1;
    // single pass of three symbols
    wr_valid = 1'b1;
    wr_code = 5'b10111; tick();
    wr_code = 5'b11010; tick();
    wr_code = 5'b01001; tick();
    wr_valid = 1'b0;
    chk("t1_count", count, 3);
    push_sym(5'b10111, 4); push_sym(5'b11010, 4); push_sym(5'b01001, 4); push_done();
    go(1'b0);
    drain();
    chk("t1_count_kept", count, 3);
    // overflow: only the first eight codes are stored
    do_clear();
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_code = 5'(i);
      chk("t2_ready", wr_ready, i < 8);
      tick();
    end
    wr_valid = 1'b0;
    chk("t2_count", count, 8);
    for (int i = 0; i < 8; i++) push_sym(5'(i), 4);
    push_done();
    go(1'b0);
    drain();
    // loop three full passes, then stop mid-dwell of the second symbol
    do_clear();
    write(5'h03);
    write(5'h1C);
    for (int p = 0; p < 3; p++) begin push_sym(5'h03, 4); push_sym(5'h1C, 4); end
    push_sym(5'h03, 4); push_sym(5'h1C, 2); push_done();
    go(1'b1);
    repeat (29) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drain();
    // writes, clear and start are ignored during playback
    do_clear();
    write(5'h0A);
    write(5'h15);
    push_sym(5'h0A, 4); push_sym(5'h15, 4); push_done();
    go(1'b0);
    wr_valid = 1'b1; wr_code = 5'h1F; clear = 1'b1; start = 1'b1;
    chk("t4_ready", wr_ready, 0);
    tick();
    chk("t4_count", count, 2);
    tick();
    wr_valid = 1'b0; clear = 1'b0; start = 1'b0;
    drain();
    chk("t4_count_end", count, 2);
    // clear beats a write; start on empty buffer does nothing
    clear = 1'b1; wr_valid = 1'b1; wr_code = 5'h05;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    chk("t5_count", count, 0);
    go(1'b0);
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    // reset in the middle of playback
    write(5'h01); write(5'h02); write(5'h04);
    push_sym(5'h01, 4); push_sym(5'h02, 2);
    go(1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_code", code, 5'b11111);
    chk("t6_ready", wr_ready, 1);
    chk("t6_left", q.size(), 0);
    go(1'b0);
    tick();
    tick();
    chk("t6_start_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
Upstream stage of the 7-segment `display` decoder. It buffers a short message of 5-bit symbol codes written through a valid/ready handshake. On command it plays the message out on C1..C5, holding each symbol for a programmable number of cycles. Its C1..C5 outputs connect directly to the C1..C5 inputs of `display`, with C1 as the code MSB.

Parameters:
DEPTH, 8, message buffer capacity in symbols (power of two, 2..32)
DWELL, 4, clock cycles each symbol stays on C1..C5 (>=1)
BLANK, 5'b11111, code driven on C1..C5 whenever no symbol is being played

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
wr_valid  input  1  write request for wr_code
wr_code  input  5  symbol code to append, bit 4 = C1 ... bit 0 = C5
wr_ready  output  1  buffer can accept a write this cycle
clear  input  1  empty the buffer (honoured in IDLE only)
start  input  1  begin playback (honoured in IDLE only)
loop  input  1  sampled at start: 1 = repeat message until stop, 0 = play once
stop  input  1  abort playback
busy  output  1  high while playing
done  output  1  one-cycle pulse when playback ends
count  output  $clog2(DEPTH)+1  number of symbols stored
C1  output  1  code bit 4 to display
C2  output  1  code bit 3
C3  output  1  code bit 2
C4  output  1  code bit 1
C5  output  1  code bit 0

Behaviour:
- Reset applies on the clk edge where rst=1.
  - Outputs: count=0, busy=0, done=0, {C1..C5}=BLANK, wr_ready=1.
  - State: FSM=IDLE, internal indices and dwell counter = 0.
  - Buffer contents do not matter after reset.
- Reset overrides every other input, including mid-playback.
- FSM states: IDLE, PLAY.
- IDLE:
  - wr_ready = (count < DEPTH), combinational.
  - A write occurs when wr_valid && wr_ready. It stores wr_code at index count, and count increments on the same edge.
  - If count = DEPTH, wr_valid is ignored and no data is stored.
  - clear=1 sets count=0. clear takes priority over a same-cycle write and over start.
  - start=1 with count>0 and clear=0 enters PLAY. It latches loop, sets idx=0 and dwell=0, and asserts busy from the next cycle.
  - start with count=0 is ignored: no done pulse, stay in IDLE.
- PLAY:
  - wr_ready=0. wr_valid, clear and start are ignored.
  - {C1..C5} = buffer[idx], registered. The first symbol appears in the cycle after the start edge, i.e. 1-cycle latency from start.
  - dwell counts 0..DWELL-1. Each symbol is therefore visible for exactly DWELL consecutive cycles.
  - At dwell=DWELL-1:
    - If idx < count-1: idx+1, dwell=0.
    - Else if looped: idx=0, dwell=0. There is no blank gap between passes.
    - Else: go to IDLE, {C1..C5}=BLANK, busy=0, and pulse done for one cycle, all on the same edge.
- stop=1 in PLAY ends playback at the next edge:
  - The FSM goes to IDLE, outputs BLANK, clears busy and pulses done.
  - stop has priority over symbol advance in the same cycle.
  - stop in IDLE has no effect.
- Buffer contents and count are preserved across playback, so the same message can be replayed with start again.
- All outputs are registered except wr_ready.
- Counter widths:
  - idx and the write pointer are $clog2(DEPTH) bits.
  - The dwell counter is wide enough for DWELL-1.
  - count is $clog2(DEPTH)+1 bits, so it can represent DEPTH.

Test Plan:
1. Reset, then write 5'b10111, 5'b11010, 5'b01001 with wr_valid held -> count=3. Pulse start with loop=0 -> C1..C5 shows 10111, then 11010, then 01001, each for exactly 4 cycles starting 1 cycle after start. done pulses once, BLANK (11111) follows, busy is high for exactly 12 cycles.
2. With DEPTH=8, hold wr_valid for 10 cycles with codes 0..9 -> wr_ready drops after the 8th accept, count=8, codes 8 and 9 are not stored. Playback shows codes 0..7 only.
3. Load 2 symbols, start with loop=1 -> the sequence repeats at least 3 times with no blank gap and no done. Assert stop mid-dwell of the second symbol -> next cycle shows BLANK, busy=0, done=1 for one cycle.
4. During PLAY, drive wr_valid=1, clear=1, start=1 -> count is unchanged, wr_ready=0, playback proceeds unaltered.
5. In IDLE, drive clear=1 together with wr_valid=1 -> count=0, nothing stored. Then start with count=0 -> busy stays 0, no done pulse.
6. Assert rst mid-playback -> the next cycle shows count=0, busy=0, done=0, C1..C5=11111. A subsequent start without writes does nothing.
